// File: rtl/tx_word_loader_if.sv
// Word handshake between the digital core (master) and the TX word loader (slave).
interface tx_word_loader_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/tx_word_loader.sv
// TX word loader: buffers core words in a small FIFO and feeds one registered
// word per word-clock cycle to the 16:1 mux tree, inserting an idle pattern when starved.
module tx_word_loader #(
    parameter int              WIDTH        = 16,
    parameter int              DEPTH        = 4,
    parameter int              START_LEVEL  = 2,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = 16'h00FF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     lsb_first,
    tx_word_loader_if.slave          bus,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               underflow_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic [7:0]         ucnt_q, ucnt_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];

    logic               push, pop, flush;
    logic [PTR_W-1:0]   wr_ptr_cur, rd_ptr_cur;
    logic [LVL_W-1:0]   level_cur;
    logic [WIDTH-1:0]   rd_word, rev_word;

    assign bus.in_ready  = rst_n && en && (level_q < LVL_W'(DEPTH));
    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign level         = level_q;
    assign underflow_cnt = ucnt_q;

    always_comb begin
        rev_word = '0;
        rd_word  = mem_q[rd_ptr_q];
        for (int i = 0; i < WIDTH; i++) begin
            rev_word[i] = rd_word[WIDTH-1-i];
        end
    end

    // IDLE (or a dropped enable) flushes the FIFO; a push in that same cycle lands in the emptied buffer.
    always_comb begin
        state_d      = state_q;
        ucnt_d       = ucnt_q;
        dout_d       = IDLE_PATTERN;
        dout_valid_d = 1'b0;
        mem_d        = mem_q;

        flush = !en || (state_q == IDLE);
        push  = bus.in_valid && bus.in_ready;
        pop   = en && (state_q == STREAM) && (level_q != '0);

        wr_ptr_cur = flush ? '0 : wr_ptr_q;
        rd_ptr_cur = flush ? '0 : rd_ptr_q;
        level_cur  = flush ? '0 : level_q;

        wr_ptr_d = wr_ptr_cur;
        rd_ptr_d = rd_ptr_cur;
        level_d  = level_cur;

        if (push) begin
            mem_d[wr_ptr_cur] = bus.in_data;
            wr_ptr_d          = wr_ptr_cur + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d     = rd_ptr_cur + PTR_W'(1);
            dout_d       = lsb_first ? rd_word : rev_word;
            dout_valid_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_cur + LVL_W'(1);
            2'b01:   level_d = level_cur - LVL_W'(1);
            default: level_d = level_cur;
        endcase

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if (level_q >= LVL_W'(START_LEVEL)) state_d = STREAM;
                STREAM: begin
                    if (level_q == '0) begin
                        state_d = FILL;
                        if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            dout_q       <= IDLE_PATTERN;
            dout_valid_q <= 1'b0;
            ucnt_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ucnt_q       <= ucnt_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
